// File: rtl/time_set_ctrl_pkg.sv
// Shared encodings for the hh:mm:ss set/run sequencer: modes, digit slots and BCD limits.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_SET_H = 2'b01,
    MODE_SET_M = 2'b10,
    MODE_SET_S = 2'b11
  } mode_e;

  localparam int unsigned DIG_S0 = 0;
  localparam int unsigned DIG_S1 = 1;
  localparam int unsigned DIG_M0 = 2;
  localparam int unsigned DIG_M1 = 3;
  localparam int unsigned DIG_H0 = 4;
  localparam int unsigned DIG_H1 = 5;

  localparam logic [3:0] BCD_ZERO     = 4'd0;
  localparam logic [3:0] BCD_UNIT_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  // Two-digit mask of the field edited in a given mode; empty in RUN.
  function automatic logic [5:0] field_mask(input mode_e m);
    logic [5:0] r;
    r = '0;
    case (m)
      MODE_SET_H: r = 6'b110000;
      MODE_SET_M: r = 6'b001100;
      MODE_SET_S: r = 6'b000011;
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_field_stepper.sv
// One two-digit BCD field stepped up/down with wrap; used for hours, minutes and seconds.
module field_stepper
  import time_ctrl_pkg::*;
(
  input  logic [3:0] unit,
  input  logic [3:0] tens,
  input  logic       up,
  input  logic       down,
  input  logic [3:0] tens_max,
  input  logic [3:0] unit_max_at_top,
  output logic [1:0] en,
  output logic [1:0] load,
  output logic [7:0] d
);

  // Fields topping out at x9 wrap through the counters' own modulus;
  // others (hours) need explicit loads at the wrap points.
  logic wrap_by_load;
  assign wrap_by_load = (unit_max_at_top != BCD_UNIT_MAX);

  always_comb begin
    en   = '0;
    load = '0;
    d    = '0;
    if (up && !down) begin
      if (wrap_by_load && unit == unit_max_at_top && tens == tens_max) begin
        load = 2'b11;
      end else begin
        en[0] = 1'b1;
        en[1] = (unit == BCD_UNIT_MAX);
      end
    end else if (down && !up) begin
      if (unit != BCD_ZERO) begin
        en[0] = 1'b1;
      end else if (!wrap_by_load) begin
        en = 2'b11;
      end else if (tens == BCD_ZERO) begin
        load = 2'b11;
        d    = {tens_max, unit_max_at_top};
      end else begin
        en[1]  = 1'b1;
        load[0] = 1'b1;
        d[3:0] = BCD_UNIT_MAX;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// hh:mm:ss sequencer: RUN carry chain plus SET_H/SET_M/SET_S editing with idle timeout.
// Optional display blink on the edited field when TIME_SET_BLINK_EN is defined.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int unsigned HOURS_MAX   = 23,
  parameter int unsigned SET_TIMEOUT = 30
) (
  input  logic        CP,
  input  logic        nCLR,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [23:0] digits,
  output logic [5:0]  en,
  output logic [5:0]  load,
  output logic        dir,
  output logic [23:0] d,
  output logic [1:0]  mode,
  output logic [5:0]  blink
);

  localparam logic [3:0] H_TENS_TOP = 4'(HOURS_MAX / 10);
  localparam logic [3:0] H_UNIT_TOP = 4'(HOURS_MAX % 10);
  localparam int unsigned TW = (SET_TIMEOUT > 1) ? $clog2(SET_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((SET_TIMEOUT == 0) ? 0 : SET_TIMEOUT - 1);

  logic [3:0] s0, s1, m0, m1, h0, h1;
  assign s0 = digits[DIG_S0*4 +: 4];
  assign s1 = digits[DIG_S1*4 +: 4];
  assign m0 = digits[DIG_M0*4 +: 4];
  assign m1 = digits[DIG_M1*4 +: 4];
  assign h0 = digits[DIG_H0*4 +: 4];
  assign h1 = digits[DIG_H1*4 +: 4];

  mode_e         mode_q, mode_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic any_btn, step_ok, step_up, step_dn;
  assign any_btn = btn_mode | btn_up | btn_down;
  // A mode press or opposing up+down cancels the step.
  assign step_ok = !btn_mode && (btn_up ^ btn_down);
  assign step_up = step_ok && btn_up;
  assign step_dn = step_ok && btn_down;

  logic [1:0] h_en, h_load, m_en, m_load, sc_en, sc_load;
  logic [7:0] h_d, m_d, sc_d;

  field_stepper u_step_h (
    .unit(h0), .tens(h1),
    .up(step_up && mode_q == MODE_SET_H), .down(step_dn && mode_q == MODE_SET_H),
    .tens_max(H_TENS_TOP), .unit_max_at_top(H_UNIT_TOP),
    .en(h_en), .load(h_load), .d(h_d)
  );

  field_stepper u_step_m (
    .unit(m0), .tens(m1),
    .up(step_up && mode_q == MODE_SET_M), .down(step_dn && mode_q == MODE_SET_M),
    .tens_max(BCD_TENS_MAX), .unit_max_at_top(BCD_UNIT_MAX),
    .en(m_en), .load(m_load), .d(m_d)
  );

  field_stepper u_step_s (
    .unit(s0), .tens(s1),
    .up(step_up && mode_q == MODE_SET_S), .down(step_dn && mode_q == MODE_SET_S),
    .tens_max(BCD_TENS_MAX), .unit_max_at_top(BCD_UNIT_MAX),
    .en(sc_en), .load(sc_load), .d(sc_d)
  );

  always_comb begin
    mode_d = mode_q;
    tmo_d  = tmo_q;
    if (btn_mode) begin
      tmo_d = '0;
      unique case (mode_q)
        MODE_RUN:   mode_d = MODE_SET_H;
        MODE_SET_H: mode_d = MODE_SET_M;
        MODE_SET_M: mode_d = MODE_SET_S;
        MODE_SET_S: mode_d = MODE_RUN;
      endcase
    end else if (btn_up || btn_down) begin
      tmo_d = '0;
    end else if (tick_1hz && mode_q != MODE_RUN && SET_TIMEOUT != 0) begin
      if (tmo_q == TMO_LAST) begin
        mode_d = MODE_RUN;
        tmo_d  = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) begin
      mode_q <= MODE_RUN;
      tmo_q  <= '0;
    end else begin
      mode_q <= mode_d;
      tmo_q  <= tmo_d;
    end
  end

  logic [5:0]  en_c, load_c;
  logic [23:0] d_c;
  logic        dir_c;
  logic        c1, c2, c3, hour_carry;

  always_comb begin
    en_c       = '0;
    load_c     = '0;
    d_c        = '0;
    dir_c      = 1'b0;
    c1         = 1'b0;
    c2         = 1'b0;
    c3         = 1'b0;
    hour_carry = 1'b0;
    unique case (mode_q)
      MODE_RUN: begin
        if (tick_1hz) begin
          dir_c      = 1'b1;
          c1         = (s0 == BCD_UNIT_MAX);
          c2         = c1 && (s1 == BCD_TENS_MAX);
          c3         = c2 && (m0 == BCD_UNIT_MAX);
          hour_carry = c3 && (m1 == BCD_TENS_MAX);
          en_c[DIG_S0] = 1'b1;
          en_c[DIG_S1] = c1;
          en_c[DIG_M0] = c2;
          en_c[DIG_M1] = c3;
          // Rolling past the last hour clears both hour digits by load.
          if (hour_carry && h1 == H_TENS_TOP && h0 == H_UNIT_TOP) begin
            load_c[DIG_H1] = 1'b1;
            load_c[DIG_H0] = 1'b1;
          end else begin
            en_c[DIG_H0] = hour_carry;
            en_c[DIG_H1] = hour_carry && (h0 == BCD_UNIT_MAX);
          end
        end
      end
      MODE_SET_H: begin
        dir_c       = step_up;
        en_c[5:4]   = h_en;
        load_c[5:4] = h_load;
        d_c[23:16]  = h_d;
      end
      MODE_SET_M: begin
        dir_c       = step_up;
        en_c[3:2]   = m_en;
        load_c[3:2] = m_load;
        d_c[15:8]   = m_d;
      end
      MODE_SET_S: begin
        dir_c       = step_up;
        en_c[1:0]   = sc_en;
        load_c[1:0] = sc_load;
        d_c[7:0]    = sc_d;
      end
    endcase
  end

  logic [5:0] blink_c;

`ifdef TIME_SET_BLINK_EN
  logic phase_q, phase_d;

  // Any press or mode change restarts the phase visible so edits show at once.
  always_comb begin
    phase_d = phase_q;
    if (any_btn || mode_d != mode_q) phase_d = 1'b0;
    else if (tick_1hz)               phase_d = ~phase_q;
  end

  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) phase_q <= 1'b0;
    else       phase_q <= phase_d;
  end

  assign blink_c = phase_q ? field_mask(mode_q) : '0;
`else
  logic unused_any_btn;
  assign unused_any_btn = any_btn;
  assign blink_c        = '0;
`endif

  assign en    = nCLR ? (en_c & ~load_c) : '0;
  assign load  = nCLR ? load_c : '0;
  assign d     = nCLR ? d_c : '0;
  assign dir   = nCLR & dir_c;
  assign mode  = nCLR ? mode_q : MODE_RUN;
  assign blink = nCLR ? blink_c : '0;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl; digits are driven directly by the bench.
module tb_time_set_ctrl;

  logic        CP = 1'b0;
  logic        nCLR, tick_1hz, btn_mode, btn_up, btn_down;
  logic [23:0] digits;
  logic [5:0]  en, load, blink;
  logic        dir;
  logic [23:0] d;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;

  time_set_ctrl #(.HOURS_MAX(23), .SET_TIMEOUT(30)) dut (
    .CP(CP), .nCLR(nCLR), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .digits(digits),
    .en(en), .load(load), .dir(dir), .d(d), .mode(mode), .blink(blink)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic t, input logic m, input logic u, input logic dn,
                        input logic [23:0] dg);
    @(negedge CP);
    tick_1hz = t; btn_mode = m; btn_up = u; btn_down = dn; digits = dg;
    #1;
  endtask

  task automatic fin();
    @(posedge CP);
    #1;
    tick_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  function automatic logic [5:0] exp_blink(input int k, input logic [5:0] mask);
`ifdef TIME_SET_BLINK_EN
    return (k % 2 == 1) ? mask : 6'b0;
`else
    return (k > 1000) ? mask : 6'b0;
`endif
  endfunction

  initial begin
    nCLR = 1'b0; tick_1hz = 1'b1; btn_mode = 1'b0; btn_up = 1'b1; btn_down = 1'b0;
    digits = 24'h235959;
    #12;
    chk("rst_mode", mode, 2'b00);
    chk("rst_en", en, 6'b0);
    chk("rst_load", load, 6'b0);
    chk("rst_d", d, 24'h0);
    chk("rst_dir", dir, 1'b0);
    chk("rst_blink", blink, 6'b0);
    @(negedge CP);
    nCLR = 1'b1; tick_1hz = 1'b0; btn_up = 1'b0;

    // RUN carries
    set_in(1, 0, 0, 0, 24'h235959);
    chk("t1_en", en, 6'b001111);
    chk("t1_load", load, 6'b110000);
    chk("t1_d", d, 24'h0);
    chk("t1_dir", dir, 1'b1);
    fin();
    chk("t1_mode", mode, 2'b00);
    set_in(1, 0, 0, 0, 24'h123456); chk("run_plain_en", en, 6'b000001); fin();
    set_in(1, 0, 0, 0, 24'h120959);
    chk("t2_en", en, 6'b001111); chk("t2_load", load, 6'b0); fin();
    set_in(1, 0, 0, 0, 24'h125959); chk("run_h0_en", en, 6'b011111); fin();
    set_in(1, 0, 0, 0, 24'h095959); chk("run_h1_en", en, 6'b111111); fin();
    set_in(0, 0, 1, 0, 24'h123456);
    chk("run_up_ign_en", en, 6'b0); chk("run_up_ign_load", load, 6'b0); fin();
    set_in(1, 1, 0, 0, 24'h123456);
    chk("run_mode_tick_en", en, 6'b000001); chk("run_mode_tick_dir", dir, 1'b1);
    fin();
    chk("enter_set_h", mode, 2'b01);

    // SET_H
    set_in(1, 0, 0, 0, 24'h235959);
    chk("seth_tick_en", en, 6'b0); chk("seth_tick_load", load, 6'b0); fin();
    chk("seth_tick_mode", mode, 2'b01);
    set_in(0, 0, 0, 1, 24'h001234);
    chk("t3_dn_load", load, 6'b110000); chk("t3_dn_d", d, 24'h230000);
    chk("t3_dn_dir", dir, 1'b0); chk("t3_dn_en", en, 6'b0); fin();
    set_in(0, 0, 1, 0, 24'h231234);
    chk("t3_up_load", load, 6'b110000); chk("t3_up_d", d, 24'h0);
    chk("t3_up_dir", dir, 1'b1); chk("t3_up_en", en, 6'b0); fin();
    set_in(0, 0, 1, 0, 24'h091234);
    chk("seth_up9_en", en, 6'b110000); chk("seth_up9_load", load, 6'b0); fin();
    set_in(0, 0, 0, 1, 24'h101234);
    chk("seth_dn10_en", en, 6'b100000); chk("seth_dn10_load", load, 6'b010000);
    chk("seth_dn10_d", d, 24'h090000); fin();
    set_in(0, 0, 0, 1, 24'h151234); chk("seth_dn15_en", en, 6'b010000); fin();
    set_in(0, 1, 0, 0, 24'h151234); fin();
    chk("enter_set_m", mode, 2'b10);

    // SET_M
    set_in(0, 0, 1, 1, 24'h123056);
    chk("t4_both_en", en, 6'b0); chk("t4_both_load", load, 6'b0); fin();
    set_in(0, 0, 1, 0, 24'h125956);
    chk("setm_up59_en", en, 6'b001100); chk("setm_up59_load", load, 6'b0); fin();
    set_in(0, 0, 0, 1, 24'h120056);
    chk("setm_dn00_en", en, 6'b001100); chk("setm_dn00_dir", dir, 1'b0); fin();
    set_in(1, 0, 0, 0, 24'h123056); fin();
    chk("t6_blink_on", blink, exp_blink(1, 6'b001100));
    set_in(0, 0, 1, 0, 24'h123056); chk("setm_up30_en", en, 6'b000100); fin();
    chk("t6_blink_btn", blink, 6'b0);
    for (int k = 1; k <= 30; k++) begin
      set_in(1, 0, 0, 0, 24'h123056); fin();
      if (k < 30) begin
        chk($sformatf("tmo_hold_%0d", k), mode, 2'b10);
        chk($sformatf("t6_blink_%0d", k), blink, exp_blink(k, 6'b001100));
      end else begin
        chk("t4_timeout_mode", mode, 2'b00);
        chk("t4_timeout_blink", blink, 6'b0);
      end
    end

    // SET_S and simultaneous mode+step
    for (int i = 0; i < 3; i++) begin set_in(0, 1, 0, 0, 24'h123456); fin(); end
    chk("enter_set_s", mode, 2'b11);
    set_in(0, 0, 0, 1, 24'h123440);
    chk("sets_dn40_en", en, 6'b000011); chk("sets_dn40_dir", dir, 1'b0); fin();
    set_in(0, 1, 1, 0, 24'h123456);
    chk("t5_modeup_en", en, 6'b0); chk("t5_modeup_load", load, 6'b0); fin();
    chk("t5_modeup_mode", mode, 2'b00);

    // Reset in the middle of SET_M
    for (int i = 0; i < 2; i++) begin set_in(0, 1, 0, 0, 24'h123456); fin(); end
    chk("rst2_pre_mode", mode, 2'b10);
    set_in(0, 0, 1, 0, 24'h123056);
    chk("rst2_pre_en", en, 6'b000100);
    nCLR = 1'b0;
    #1;
    chk("t5_rst_mode", mode, 2'b00);
    chk("t5_rst_en", en, 6'b0);
    chk("t5_rst_dir", dir, 1'b0);
    fin();
    @(negedge CP);
    nCLR = 1'b1;
    @(posedge CP); #1;
    chk("t5_post_mode", mode, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
